sv39_ptw: RTL and testbench

SV39_PTW -- requirements
Module: sv39_ptw

---
 rtl/sv39_ptw_pkg.sv | 54 +++++
 rtl/sv39_ptw_if.sv | 25 ++
 rtl/sv39_ptw_pte_check.sv | 53 +++++
 rtl/sv39_ptw.sv | 123 ++++++++++++
 tb/tb_sv39_ptw.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sv39_ptw_pkg.sv
// Shared Sv39 walker types: FSM states, SATP mode, PTE bit positions, VA/PTE layouts.
// Pure declarations; no logic, no latency, no flow control.
package sv39_ptw_pkg;

  typedef enum logic [3:0] {
    IDLE,
    READ_L1,
    WAIT_L1,
    READ_L2,
    WAIT_L2,
    READ_L3,
    WAIT_L3,
    READ_DATA,
    WAIT_DATA,
    OUTPUT
  } mmu_state_t;

  localparam logic [3:0] SATP_MODE_SV39 = 4'h8;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_PPN_LSB = 10;
  localparam int PTE_PPN_MSB = 53;

  typedef struct packed {
    logic [8:0]  vpn2;
    logic [8:0]  vpn1;
    logic [8:0]  vpn0;
    logic [11:0] offset;
  } sv39_va_t;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } pte_t;

  function automatic logic [63:0] pa_mask(input int width);
    logic [63:0] m;
    for (int i = 0; i < 64; i++) m[i] = (i < width);
    return m;
  endfunction

endpackage

// File: rtl/sv39_ptw_if.sv
// Request/response and PTE-memory handshake bundle for the walker.
// slave = walker side, master = requester plus memory side.
interface sv39_ptw_if;
  logic        req_valid;
  logic [63:0] req_vaddr;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  logic        mem_valid;
  logic [63:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [63:0] mem_rdata;

  modport slave (
    input  req_valid, req_vaddr, mem_addr_ok, mem_data_ok, mem_rdata,
    output req_ready, resp_valid, resp_paddr, resp_fault, mem_valid, mem_addr
  );

  modport master (
    output req_valid, req_vaddr, mem_addr_ok, mem_data_ok, mem_rdata,
    input  req_ready, resp_valid, resp_paddr, resp_fault, mem_valid, mem_addr
  );
endinterface

// File: rtl/sv39_ptw_pte_check.sv
// Combinational PTE decode for one walk level: leaf/fault, next-level PTE address, leaf paddr.
// Zero latency, no flow control; level 0/1/2 = L1 (1 GiB) / L2 (2 MiB) / L3 (4 KiB).
module sv39_ptw_pte_check
  import sv39_ptw_pkg::*;
#(
  parameter int PA_WIDTH = 56
) (
  input  pte_t        pte,
  input  logic [1:0]  level,
  input  sv39_va_t    va,
  output logic        leaf,
  output logic        fault,
  output logic [63:0] next_addr,
  output logic [63:0] paddr
);

  localparam logic [63:0] PA_MASK = pa_mask(PA_WIDTH);

  logic        misaligned;
  logic [55:0] leaf_pa;
  logic        unused_bits;

  // A/D/U/G are the requester's business; only V/R/W/X and the PPN matter here.
  assign unused_bits = ^{pte.reserved, pte.rsw, pte.d, pte.a, pte.g, pte.u, va.vpn2};
  assign leaf        = pte.r | pte.x;

  // Superpages take their low PPN fields from the virtual address.
  always_comb begin
    misaligned = 1'b0;
    leaf_pa    = {pte.ppn, va.offset};
    case (level)
      2'd0: begin
        misaligned = |pte.ppn[17:0];
        leaf_pa    = {pte.ppn[43:18], va.vpn1, va.vpn0, va.offset};
      end
      2'd1: begin
        misaligned = |pte.ppn[8:0];
        leaf_pa    = {pte.ppn[43:9], va.vpn0, va.offset};
      end
      default: ;
    endcase
  end

  always_comb begin
    if (!pte.v || (!pte.r && pte.w)) fault = 1'b1;
    else if (leaf)                   fault = misaligned;
    else                             fault = (level >= 2'd2);
  end

  assign paddr     = (fault || !leaf) ? 64'h0 : ({8'h00, leaf_pa} & PA_MASK);
  assign next_addr = {8'h00, pte.ppn, (level == 2'd0) ? va.vpn1 : va.vpn0, 3'b000};

endmodule

// File: rtl/sv39_ptw.sv
// Sv39 page-table walker: up to three PTE reads, one-cycle resp_valid pulse one cycle after the last data.
// Accepts only in IDLE; memory reads wait on mem_addr_ok/mem_data_ok; flush aborts, draining any issued read.
module sv39_ptw
  import sv39_ptw_pkg::*;
#(
  parameter int PA_WIDTH = 56
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] satp,
  input  logic [1:0]  priv,
  input  logic        flush,
  sv39_ptw_if.slave   bus
);

  localparam logic [63:0] PA_MASK = pa_mask(PA_WIDTH);

  mmu_state_t  state, state_nxt;
  logic        abort, abort_nxt;
  logic [63:0] va_q;
  logic [43:0] root_q;
  logic [3:0]  mode_q;
  logic [1:0]  priv_q;
  logic [63:0] paddr_q, next_q;
  logic        fault_q;

  logic        accept, bypass_in, bypass_q, is_read, is_wait, walk_eval;
  logic [1:0]  level;
  logic        chk_leaf, chk_fault;
  logic [63:0] chk_next, chk_paddr;

  assign bypass_in = (priv == 2'd3) || (satp[63:60] != SATP_MODE_SV39);
  assign bypass_q  = (priv_q == 2'd3) || (mode_q != SATP_MODE_SV39);
  assign accept    = (state == IDLE) && bus.req_valid && !flush;
  assign is_read   = state inside {READ_L1, READ_L2, READ_L3};
  assign is_wait   = state inside {WAIT_L1, WAIT_L2, WAIT_L3};
  assign level     = (state == WAIT_L1) ? 2'd0 : (state == WAIT_L2) ? 2'd1 : 2'd2;
  assign walk_eval = is_wait && bus.mem_data_ok && !abort && !flush;

  sv39_ptw_pte_check #(.PA_WIDTH(PA_WIDTH)) u_pte_check (
    .pte       (pte_t'(bus.mem_rdata)),
    .level     (level),
    .va        (sv39_va_t'(va_q[38:0])),
    .leaf      (chk_leaf),
    .fault     (chk_fault),
    .next_addr (chk_next),
    .paddr     (chk_paddr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // An issued read must still be drained after flush, so abort is held until its data returns.
  always_comb begin
    state_nxt = state;
    abort_nxt = abort;
    case (state)
      IDLE: if (accept) state_nxt = bypass_in ? OUTPUT : READ_L1;
      READ_L1, READ_L2, READ_L3: begin
        if (bus.mem_addr_ok) begin
          state_nxt = (state == READ_L1) ? WAIT_L1 : (state == READ_L2) ? WAIT_L2 : WAIT_L3;
          abort_nxt = flush;
        end else if (flush) begin
          state_nxt = IDLE;
        end
      end
      WAIT_L1, WAIT_L2, WAIT_L3: begin
        if (bus.mem_data_ok) begin
          abort_nxt = 1'b0;
          if (abort || flush)           state_nxt = IDLE;
          else if (chk_fault || chk_leaf) state_nxt = OUTPUT;
          else                          state_nxt = (state == WAIT_L1) ? READ_L2 : READ_L3;
        end else if (flush) begin
          abort_nxt = 1'b1;
        end
      end
      OUTPUT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      abort   <= 1'b0;
      va_q    <= '0;
      root_q  <= '0;
      mode_q  <= '0;
      priv_q  <= '0;
      paddr_q <= '0;
      next_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      abort <= abort_nxt;
      if (accept) begin
        va_q   <= bus.req_vaddr;
        root_q <= satp[43:0];
        mode_q <= satp[63:60];
        priv_q <= priv;
      end
      if (walk_eval) begin
        paddr_q <= chk_paddr;
        fault_q <= chk_fault;
        next_q  <= chk_next;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.mem_valid  = is_read;
    bus.resp_valid = (state == OUTPUT) && !flush;
    bus.resp_paddr = bypass_q ? (va_q & PA_MASK) : paddr_q;
    bus.resp_fault = !bypass_q && fault_q;
    case (state)
      READ_L1:          bus.mem_addr = {8'h00, root_q, va_q[38:30], 3'b000};
      READ_L2, READ_L3: bus.mem_addr = next_q;
      default:          bus.mem_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_sv39_ptw.sv
// Directed bench for sv39_ptw: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_sv39_ptw;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] satp;
  logic [1:0]  priv;
  logic        flush;

  sv39_ptw_if bus();

  sv39_ptw #(.PA_WIDTH(56)) dut (
    .clk   (clk),
    .reset (reset),
    .satp  (satp),
    .priv  (priv),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] paddr;
    logic        fault;
    int          cyc;
  } exp_t;

  localparam logic [63:0] SATP_SV39 = 64'h8000_0000_0008_0000;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          memv_cnt = 0;
  logic [63:0] adr_tab[3];
  logic [63:0] pte_tab[3];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (bus.mem_valid) memv_cnt++;
      if (bus.resp_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_resp: got paddr=%h fault=%b at cyc %0d, required no response",
                   bus.resp_paddr, bus.resp_fault, cyc);
        end else begin
          e = exp_q.pop_front();
          if (bus.resp_paddr !== e.paddr || bus.resp_fault !== e.fault || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL resp: got paddr=%h fault=%b cyc=%0d, required paddr=%h fault=%b cyc=%0d",
                     bus.resp_paddr, bus.resp_fault, cyc, e.paddr, e.fault, e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] va, input logic [63:0] s, input logic [1:0] p);
    bit ok = 1'b0;
    satp = s;
    priv = p;
    bus.req_vaddr = va;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
    end
    tick();
    bus.req_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1");
    end
  endtask

  task automatic wait_memv(input string name, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: mem_valid stayed 0, required 1", name);
    end
  endtask

  task automatic serve_addr(input string name, input logic [63:0] exp);
    bit seen;
    wait_memv(name, seen);
    if (seen) check({name, "_addr"}, bus.mem_addr, exp);
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0;
  endtask

  task automatic serve_data(input logic [63:0] pte, input int delay);
    repeat (delay) @(posedge clk);
    @(negedge clk);
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata   = pte;
    tick();
    bus.mem_data_ok = 1'b0;
  endtask

  task automatic settle(input string name);
    repeat (3) tick();
    @(negedge clk);
    check({name, "_idle"}, {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();
  endtask

  task automatic walk(input string name, input logic [63:0] va, input int n,
                      input logic [63:0] exp_pa, input logic exp_fault);
    issue(va, SATP_SV39, 2'd1);
    for (int i = 0; i < n; i++) begin
      serve_addr(name, adr_tab[i]);
      serve_data(pte_tab[i], i);
    end
    exp_q.push_back(exp_t'{exp_pa, exp_fault, cyc});
    settle(name);
  endtask

  task automatic bypass(input string name, input logic [63:0] va, input logic [63:0] s,
                        input logic [1:0] p);
    int snap = memv_cnt;
    issue(va, s, p);
    exp_q.push_back(exp_t'{va, 1'b0, cyc});
    settle(name);
    check({name, "_nomem"}, memv_cnt - snap, 0);
  endtask

  task automatic load_4k();
    adr_tab = '{64'h8000_0008, 64'h8000_0000, 64'h8000_1000};
    pte_tab = '{64'h2000_0001, 64'h2000_0401, 64'h2000_080F};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    reset = 1'b0;
    satp = '0;
    priv = '0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_vaddr = '0;
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.mem_valid, bus.resp_fault}, 4'b1000);
    check("rst_mem_addr", bus.mem_addr, 64'h0);
    check("rst_resp_paddr", bus.resp_paddr, 64'h0);
    tick();

    bypass("byp_priv", 64'h8000_1234, SATP_SV39, 2'd3);
    bypass("byp_bare", 64'h0000_0012_3456_789a, 64'h0, 2'd0);

    load_4k();
    walk("walk_4k", 64'h4000_0abc, 3, 64'h8000_2abc, 1'b0);

    adr_tab[0] = 64'h8000_0080;
    pte_tab[0] = 64'h2000_000F;
    walk("walk_1g", 64'h4_1234_5678, 1, 64'h9234_5678, 1'b0);
    pte_tab[0] = 64'h2000_040F;
    walk("misalign_1g", 64'h4_1234_5678, 1, 64'h0, 1'b1);
    pte_tab[0] = 64'h0;
    walk("pte_invalid", 64'h4_1234_5678, 1, 64'h0, 1'b1);
    pte_tab[0] = 64'h5;
    walk("pte_w_no_r", 64'h4_1234_5678, 1, 64'h0, 1'b1);

    adr_tab = '{64'h8000_0008, 64'h8000_0000, 64'h0};
    pte_tab = '{64'h2000_0001, 64'h2008_000F, 64'h0};
    walk("walk_2m", 64'h4000_5abc, 2, 64'h8020_5abc, 1'b0);

    load_4k();
    pte_tab[2] = 64'h2000_0801;
    walk("l3_nonleaf", 64'h4000_0abc, 3, 64'h0, 1'b1);

    // Flush while the first read is still waiting for mem_addr_ok.
    issue(64'h4000_0abc, SATP_SV39, 2'd1);
    wait_memv("flush_read", seen);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_read_idle", {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();

    // Flush together with req_valid in IDLE must not accept.
    flush = 1'b1;
    satp = SATP_SV39;
    priv = 2'd1;
    bus.req_vaddr = 64'h4000_0abc;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle_noaccept", {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();

    // Flush during OUTPUT swallows the response.
    issue(64'h0000_0000_0000_1000, SATP_SV39, 2'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_output_idle", {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();

    // Flush in WAIT_L2, data arrives three cycles later.
    load_4k();
    issue(64'h4000_0abc, SATP_SV39, 2'd1);
    serve_addr("flush_wait", adr_tab[0]);
    serve_data(pte_tab[0], 0);
    serve_addr("flush_wait_l2", adr_tab[1]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    @(negedge clk);
    check("flush_wait_busy", {bus.req_ready, bus.mem_valid}, 2'b00);
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata = pte_tab[1];
    tick();
    bus.mem_data_ok = 1'b0;
    @(negedge clk);
    check("flush_wait_idle", {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();
    walk("after_flush", 64'h4000_0abc, 3, 64'h8000_2abc, 1'b0);

    // Reset in WAIT_L1, then a stray data beat after release.
    issue(64'h4000_0abc, SATP_SV39, 2'd1);
    serve_addr("rst_mid", adr_tab[0]);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {bus.req_ready, bus.resp_valid, bus.mem_valid, bus.resp_fault}, 4'b1000);
    check("rst_mid_paddr", bus.resp_paddr, 64'h0);
    check("rst_mid_addr", bus.mem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    @(negedge clk);
    bus.mem_data_ok = 1'b1;
    bus.mem_rdata = pte_tab[0];
    tick();
    bus.mem_data_ok = 1'b0;
    @(negedge clk);
    check("stray_data_idle", {bus.req_ready, bus.mem_valid}, 2'b10);
    tick();
    walk("after_reset", 64'h4000_0abc, 3, 64'h8000_2abc, 1'b0);

    repeat (5) tick();
    check("pending_resp", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
